// File: rtl/upcount_ctrl.sv
// Sequencing controller for an external 8-bit load/increment up counter.
// Define UPCOUNT_CTRL_RELOAD_EN to honour auto_rl (auto-reload and reload_cnt).
module upcount_ctrl #(
  parameter int unsigned DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       halt,
  input  logic       abort,
  input  logic       auto_rl,
  input  logic [7:0] start_val,
  input  logic [7:0] end_val,
  input  logic [7:0] cnt_q,
  output logic       cnt_ld,
  output logic       cnt_inc,
  output logic [7:0] cnt_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] reload_cnt
);

  localparam logic [7:0] DivLast = 8'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] start_q, start_d;
  logic [7:0] end_q, end_d;
  logic       arl_q, arl_d;
  logic [7:0] div_q, div_d;
  logic       done_q, done_d;
  logic [7:0] rl_q, rl_d;
  logic       terminal_s;

  assign terminal_s = (cnt_q == end_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      start_q <= 8'd0;
      end_q   <= 8'd0;
      arl_q   <= 1'b0;
      div_q   <= 8'd0;
      done_q  <= 1'b0;
      rl_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      end_q   <= end_d;
      arl_q   <= arl_d;
      div_q   <= div_d;
      done_q  <= done_d;
      rl_q    <= rl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    end_d   = end_q;
    arl_d   = arl_q;
    div_d   = div_q;
    done_d  = 1'b0;
    rl_d    = rl_q;
    cnt_ld  = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_LOAD;
          start_d = start_val;
          end_d   = end_val;
`ifdef UPCOUNT_CTRL_RELOAD_EN
          arl_d   = auto_rl;
`else
          arl_d   = 1'b0 & auto_rl;
`endif
          rl_d    = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_ld  = 1'b1;
          div_d   = 8'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Terminal detection outranks pacing; the increment is suppressed that cycle.
        if (abort) begin
          state_d = S_IDLE;
        end else if (terminal_s) begin
          done_d = 1'b1;
          if (arl_q) begin
            state_d = S_LOAD;
            rl_d    = (rl_q == 8'hFF) ? rl_q : rl_q + 8'd1;
          end else begin
            state_d = S_DONE;
          end
        end else if (!halt) begin
          if (div_q == DivLast) begin
            cnt_inc = 1'b1;
            div_d   = 8'd0;
          end else begin
            div_d   = div_q + 8'd1;
          end
        end else begin
          div_d = div_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cnt_data   = start_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign reload_cnt = rl_q;

endmodule
